// File: rtl/lsu_mem_stage_if.sv
// Port bundles for the memory stage: execute->stage handshake, stage->data-bus, stage->writeback.
// Each interface carries a master (producer) and slave (consumer) modport.
interface lsu_ex_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] ex_result;
   logic [XLEN-1:0] store_data;
   logic [2:0]      funct3;
   logic            mem_ren;
   logic            mem_wen;
   logic [4:0]      rd;
   logic            R_wen;
   logic [3:0]      csr_wen;
   logic [XLEN-1:0] rd_value;
   logic            jump_flag;
   logic [XLEN-1:0] pc;

   modport master (output in_valid, ex_result, store_data, funct3, mem_ren, mem_wen, rd,
                          R_wen, csr_wen, rd_value, jump_flag, pc,
                   input  in_ready);
   modport slave  (input  in_valid, ex_result, store_data, funct3, mem_ren, mem_wen, rd,
                          R_wen, csr_wen, rd_value, jump_flag, pc,
                   output in_ready);
endinterface

interface lsu_bus_if #(parameter int ADDR_W = 32, parameter int XLEN = 32);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [3:0]        mem_wstrb;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

interface lsu_wb_if #(parameter int XLEN = 32);
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] wb_MEM_Rdata;
   logic [XLEN-1:0] wb_Ex_result;
   logic [XLEN-1:0] wb_rd_value;
   logic [4:0]      wb_rd;
   logic            wb_R_wen;
   logic [3:0]      wb_csr_wen;
   logic            wb_jump_flag;
   logic            wb_mem_ren;
   logic [XLEN-1:0] wb_pc;
   logic            wb_misalign;

   modport master (output out_valid, wb_MEM_Rdata, wb_Ex_result, wb_rd_value, wb_rd, wb_R_wen,
                          wb_csr_wen, wb_jump_flag, wb_mem_ren, wb_pc, wb_misalign,
                   input  out_ready);
   modport slave  (input  out_valid, wb_MEM_Rdata, wb_Ex_result, wb_rd_value, wb_rd, wb_R_wen,
                          wb_csr_wen, wb_jump_flag, wb_mem_ren, wb_pc, wb_misalign,
                   output out_ready);
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32I memory stage: accepts one instruction, performs an aligned load/store on the data bus
// with byte-lane steering and load extension, then holds a registered result for writeback.
module lsu_mem_stage #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 32
) (
   input  logic      clock,
   input  logic      reset,
   lsu_ex_if.slave   ex,
   lsu_bus_if.master bus,
   lsu_wb_if.master  wb
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, OUT = 2'd3} state_e;

   // Access size code: 0 = byte, 1 = half, 2 = word. Unused codes fall back to word.
   function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic is_load);
      logic [1:0] sz;
      case (f3)
         3'b000:  sz = 2'd0;
         3'b001:  sz = 2'd1;
         3'b100:  sz = is_load ? 2'd0 : 2'd2;
         3'b101:  sz = is_load ? 2'd1 : 2'd2;
         default: sz = 2'd2;
      endcase
      return sz;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic mis;
      case (sz)
         2'd0:    mis = 1'b0;
         2'd1:    mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

   function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                   input logic [1:0] sz, input logic uns,
                                                   input logic [1:0] off);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (sz)
         2'd0:    r = uns ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
         2'd1:    r = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

   state_e            state_q, state_d;
   logic              in_ready_q, mem_req_q, out_valid_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [XLEN-1:0]   mem_wdata_q;
   logic [3:0]        mem_wstrb_q;
   logic              load_q, uns_q;
   logic [1:0]        size_q, off_q;
   logic [XLEN-1:0]   wb_rdata_q, wb_ex_result_q, wb_rd_value_q, wb_pc_q;
   logic [4:0]        wb_rd_q;
   logic              wb_r_wen_q, wb_jump_flag_q, wb_mem_ren_q, wb_misalign_q;
   logic [3:0]        wb_csr_wen_q;

   logic              is_load_s, is_store_s, mem_op_s, misalign_s;
   logic [1:0]        size_s, off_s;
   logic [XLEN-1:0]   wdata_s;
   logic [3:0]        wstrb_s;
   logic              capture_s;

   assign is_load_s  = ex.mem_ren;
   assign is_store_s = ex.mem_wen & ~ex.mem_ren;
   assign mem_op_s   = ex.mem_ren | ex.mem_wen;
   assign off_s      = ex.ex_result[1:0];
   assign size_s     = acc_size(ex.funct3, is_load_s);
   assign misalign_s = mem_op_s & is_misaligned(size_s, off_s);
   assign capture_s  = ((state_q == REQ) && bus.mem_gnt && load_q && bus.mem_rvalid) ||
                       ((state_q == RESP) && bus.mem_rvalid);

   // Store lane steering; loads drive zero strobes and data.
   always_comb begin
      wdata_s = {XLEN{1'b0}};
      wstrb_s = 4'b0000;
      if (is_store_s) begin
         case (size_s)
            2'd0: begin
               wstrb_s = 4'b0001 << off_s;
               wdata_s = {4{ex.store_data[7:0]}};
            end
            2'd1: begin
               wstrb_s = 4'b0011 << off_s;
               wdata_s = {2{ex.store_data[15:0]}};
            end
            default: begin
               wstrb_s = 4'b1111;
               wdata_s = ex.store_data;
            end
         endcase
      end else begin
         wdata_s = {XLEN{1'b0}};
         wstrb_s = 4'b0000;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ex.in_valid) begin
               if (!mem_op_s || misalign_s) state_d = OUT;
               else                         state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (bus.mem_gnt) begin
               if (load_q && !bus.mem_rvalid) state_d = RESP;
               else                           state_d = OUT;
            end else begin
               state_d = REQ;
            end
         end
         RESP: begin
            if (bus.mem_rvalid) state_d = OUT;
            else                state_d = RESP;
         end
         OUT: begin
            if (wb.out_ready) state_d = IDLE;
            else              state_d = OUT;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, handshake flags, bus request fields and writeback payload.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= IDLE;
         in_ready_q     <= 1'b1;
         mem_req_q      <= 1'b0;
         out_valid_q    <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= {ADDR_W{1'b0}};
         mem_wdata_q    <= {XLEN{1'b0}};
         mem_wstrb_q    <= 4'b0000;
         load_q         <= 1'b0;
         uns_q          <= 1'b0;
         size_q         <= 2'd0;
         off_q          <= 2'd0;
         wb_rdata_q     <= {XLEN{1'b0}};
         wb_ex_result_q <= {XLEN{1'b0}};
         wb_rd_value_q  <= {XLEN{1'b0}};
         wb_pc_q        <= {XLEN{1'b0}};
         wb_rd_q        <= 5'd0;
         wb_r_wen_q     <= 1'b0;
         wb_jump_flag_q <= 1'b0;
         wb_mem_ren_q   <= 1'b0;
         wb_misalign_q  <= 1'b0;
         wb_csr_wen_q   <= 4'b0000;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= (state_d == IDLE);
         mem_req_q   <= (state_d == REQ);
         out_valid_q <= (state_d == OUT);

         if ((state_q == IDLE) && (state_d == REQ)) begin
            mem_we_q    <= is_store_s;
            mem_addr_q  <= {ex.ex_result[ADDR_W-1:2], 2'b00};
            mem_wdata_q <= wdata_s;
            mem_wstrb_q <= wstrb_s;
         end else if (state_d != REQ) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
            mem_wstrb_q <= 4'b0000;
         end

         if ((state_q == IDLE) && ex.in_valid) begin
            load_q         <= is_load_s;
            uns_q          <= ex.funct3[2];
            size_q         <= size_s;
            off_q          <= off_s;
            wb_rdata_q     <= {XLEN{1'b0}};
            wb_ex_result_q <= ex.ex_result;
            wb_rd_value_q  <= ex.rd_value;
            wb_pc_q        <= ex.pc;
            wb_rd_q        <= ex.rd;
            wb_r_wen_q     <= ex.R_wen & ~misalign_s;
            wb_jump_flag_q <= ex.jump_flag;
            wb_mem_ren_q   <= ex.mem_ren;
            wb_misalign_q  <= misalign_s;
            wb_csr_wen_q   <= ex.csr_wen;
         end else if (capture_s) begin
            wb_rdata_q <= load_extend(bus.mem_rdata, size_q, uns_q, off_q);
         end
      end
   end

   assign ex.in_ready     = in_ready_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.mem_wstrb   = mem_wstrb_q;
   assign wb.out_valid    = out_valid_q;
   assign wb.wb_MEM_Rdata = wb_rdata_q;
   assign wb.wb_Ex_result = wb_ex_result_q;
   assign wb.wb_rd_value  = wb_rd_value_q;
   assign wb.wb_rd        = wb_rd_q;
   assign wb.wb_R_wen     = wb_r_wen_q;
   assign wb.wb_csr_wen   = wb_csr_wen_q;
   assign wb.wb_jump_flag = wb_jump_flag_q;
   assign wb.wb_mem_ren   = wb_mem_ren_q;
   assign wb.wb_pc        = wb_pc_q;
   assign wb.wb_misalign  = wb_misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized transactions
// checked against an arithmetic reference model of the load/store rules.
module tb_lsu_mem_stage;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   lsu_ex_if  ex_if ();
   lsu_bus_if bus_if ();
   lsu_wb_if  wb_if ();

   lsu_mem_stage dut (
      .clock (clock),
      .reset (reset),
      .ex    (ex_if),
      .bus   (bus_if),
      .wb    (wb_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: access width in bytes.
   function automatic int ref_bytes(input bit ld, input bit [2:0] f3);
      if (ld) begin
         if (f3 == 3'd0 || f3 == 3'd4) return 1;
         if (f3 == 3'd1 || f3 == 3'd5) return 2;
         return 4;
      end
      if (f3 == 3'd0) return 1;
      if (f3 == 3'd1) return 2;
      return 4;
   endfunction

   function automatic bit [31:0] ref_load(input bit [31:0] rdat, input int n, input bit sgn,
                                          input int off);
      longint unsigned v;
      longint unsigned span;
      span = 64'd1 << (8 * n);
      v = (64'(rdat) >> (8 * off)) % span;
      if (sgn && n < 4 && v >= span / 2) v = v + (64'hFFFF_FFFF_FFFF_FFFF - span + 64'd1);
      return v[31:0];
   endfunction

   function automatic bit [31:0] ref_wdata(input bit [31:0] sd, input int n);
      if (n == 1) return (sd % 32'h100) * 32'h0101_0101;
      if (n == 2) return (sd % 32'h1_0000) * 32'h0001_0001;
      return sd;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic scramble_ex();
      ex_if.ex_result  = $urandom;
      ex_if.store_data = $urandom;
      ex_if.funct3     = 3'($urandom_range(0, 7));
      ex_if.mem_ren    = 1'($urandom_range(0, 1));
      ex_if.mem_wen    = 1'($urandom_range(0, 1));
      ex_if.rd         = 5'($urandom_range(0, 31));
      ex_if.R_wen      = 1'($urandom_range(0, 1));
      ex_if.csr_wen    = 4'($urandom_range(0, 15));
      ex_if.rd_value   = $urandom;
      ex_if.jump_flag  = 1'($urandom_range(0, 1));
      ex_if.pc         = $urandom;
   endtask

   task automatic run_txn(input bit ren, input bit wen, input bit [2:0] f3, input bit [31:0] ea,
                          input bit [31:0] sd, input bit [31:0] rdat, input int gd,
                          input int rvd, input int od, input bit poke);
      bit        ld, st, memop, mis, sgn;
      int        n, off;
      bit [31:0] e_addr, e_wdata, e_load;
      bit [3:0]  e_wstrb;
      bit [4:0]  rdn;
      bit        rwen, jmp;
      bit [3:0]  csr;
      bit [31:0] rdv, pcv;

      ld      = ren;
      st      = wen && !ren;
      memop   = ren || wen;
      n       = ref_bytes(ld, f3);
      off     = int'(ea % 4);
      mis     = memop && (ea % n != 0);
      sgn     = ld && (f3 == 3'd0 || f3 == 3'd1);
      e_addr  = ea - (ea % 4);
      e_wstrb = st ? 4'(((1 << n) - 1) << off) : 4'b0000;
      e_wdata = st ? ref_wdata(sd, n) : 32'd0;
      e_load  = (ld && !mis) ? ref_load(rdat, n, sgn, off) : 32'd0;
      rdn     = 5'($urandom_range(0, 31));
      rwen    = 1'($urandom_range(0, 1));
      jmp     = 1'($urandom_range(0, 1));
      csr     = 4'($urandom_range(0, 15));
      rdv     = $urandom;
      pcv     = $urandom;

      check("in_ready_idle", 32'(ex_if.in_ready), 32'd1);
      ex_if.in_valid   = 1'b1;
      ex_if.ex_result  = ea;
      ex_if.store_data = sd;
      ex_if.funct3     = f3;
      ex_if.mem_ren    = ren;
      ex_if.mem_wen    = wen;
      ex_if.rd         = rdn;
      ex_if.R_wen      = rwen;
      ex_if.csr_wen    = csr;
      ex_if.rd_value   = rdv;
      ex_if.jump_flag  = jmp;
      ex_if.pc         = pcv;
      tick();
      ex_if.in_valid = 1'b0;
      scramble_ex();

      if (memop && !mis) begin
         for (int c = 0; c <= gd; c++) begin
            check("mem_req", 32'(bus_if.mem_req), 32'd1);
            check("mem_addr", bus_if.mem_addr, e_addr);
            check("mem_we", 32'(bus_if.mem_we), 32'(st));
            check("mem_wdata", bus_if.mem_wdata, e_wdata);
            check("mem_wstrb", 32'(bus_if.mem_wstrb), 32'(e_wstrb));
            check("out_valid_req", 32'(wb_if.out_valid), 32'd0);
            bus_if.mem_gnt    = (c == gd);
            bus_if.mem_rvalid = (c == gd) && ld && (rvd == 0);
            bus_if.mem_rdata  = bus_if.mem_rvalid ? rdat : $urandom;
            tick();
         end
         bus_if.mem_gnt    = 1'b0;
         bus_if.mem_rvalid = 1'b0;
         if (ld && rvd > 0) begin
            for (int c = 1; c <= rvd; c++) begin
               check("mem_req_resp", 32'(bus_if.mem_req), 32'd0);
               check("out_valid_resp", 32'(wb_if.out_valid), 32'd0);
               bus_if.mem_rvalid = (c == rvd);
               bus_if.mem_rdata  = (c == rvd) ? rdat : $urandom;
               tick();
            end
            bus_if.mem_rvalid = 1'b0;
         end
      end else begin
         check("no_mem_req", 32'(bus_if.mem_req), 32'd0);
      end

      for (int c = 0; c <= od; c++) begin
         check("out_valid", 32'(wb_if.out_valid), 32'd1);
         check("in_ready_out", 32'(ex_if.in_ready), 32'd0);
         check("mem_req_out", 32'(bus_if.mem_req), 32'd0);
         check("wb_MEM_Rdata", wb_if.wb_MEM_Rdata, e_load);
         check("wb_Ex_result", wb_if.wb_Ex_result, ea);
         check("wb_rd_value", wb_if.wb_rd_value, rdv);
         check("wb_rd", 32'(wb_if.wb_rd), 32'(rdn));
         check("wb_R_wen", 32'(wb_if.wb_R_wen), 32'(rwen && !mis));
         check("wb_csr_wen", 32'(wb_if.wb_csr_wen), 32'(csr));
         check("wb_jump_flag", 32'(wb_if.wb_jump_flag), 32'(jmp));
         check("wb_mem_ren", 32'(wb_if.wb_mem_ren), 32'(ren));
         check("wb_pc", wb_if.wb_pc, pcv);
         check("wb_misalign", 32'(wb_if.wb_misalign), 32'(mis));
         wb_if.out_ready = (c == od);
         ex_if.in_valid  = poke && (c < od);
         tick();
      end
      wb_if.out_ready = 1'b0;
      ex_if.in_valid  = 1'b0;
      check("out_valid_drained", 32'(wb_if.out_valid), 32'd0);
      check("in_ready_back", 32'(ex_if.in_ready), 32'd1);
   endtask

   initial begin
      ex_if.in_valid    = 1'b0;
      scramble_ex();
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = 32'd0;
      wb_if.out_ready   = 1'b0;
      repeat (3) tick();

      check("rst_in_ready", 32'(ex_if.in_ready), 32'd1);
      check("rst_out_valid", 32'(wb_if.out_valid), 32'd0);
      check("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
      check("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
      check("rst_wb_Ex_result", wb_if.wb_Ex_result, 32'd0);
      reset = 1'b1;
      tick();

      // ALU op, LB/LBU with 2-cycle response, SH, stalled LW, slow writeback, misaligned LW
      run_txn(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'd0, 32'd0, 0, 0, 0, 1'b0);
      run_txn(1'b1, 1'b0, 3'd0, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 2, 0, 1'b0);
      run_txn(1'b1, 1'b0, 3'd4, 32'h0000_0103, 32'd0, 32'h80FF_0000, 0, 2, 0, 1'b0);
      run_txn(1'b0, 1'b1, 3'd1, 32'h0000_0202, 32'hABCD_1234, 32'd0, 0, 0, 0, 1'b0);
      run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0400, 32'd0, 32'hDEAD_BEEF, 3, 0, 0, 1'b0);
      run_txn(1'b0, 1'b0, 3'd0, 32'h0000_5555, 32'd0, 32'd0, 0, 0, 4, 1'b1);
      run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0102, 32'd0, 32'd0, 0, 0, 0, 1'b0);
      run_txn(1'b1, 1'b1, 3'd5, 32'h0000_0302, 32'h1111_2222, 32'h8001_7FFF, 1, 1, 1, 1'b0);
      run_txn(1'b0, 1'b1, 3'd7, 32'h0000_0504, 32'hCAFE_F00D, 32'd0, 2, 0, 0, 1'b0);

      // Reset while waiting for a load response abandons the access
      check("rst_mid_in_ready", 32'(ex_if.in_ready), 32'd1);
      ex_if.in_valid  = 1'b1;
      ex_if.ex_result = 32'h0000_0600;
      ex_if.funct3    = 3'd2;
      ex_if.mem_ren   = 1'b1;
      ex_if.mem_wen   = 1'b0;
      tick();
      ex_if.in_valid = 1'b0;
      check("rst_mid_req", 32'(bus_if.mem_req), 32'd1);
      bus_if.mem_gnt = 1'b1;
      tick();
      bus_if.mem_gnt = 1'b0;
      check("rst_mid_resp_wait", 32'(wb_if.out_valid), 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("rst_mid_wb_clear", wb_if.wb_Ex_result, 32'd0);
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_gnt    = 1'b1;
      bus_if.mem_rdata  = 32'h1234_5678;
      tick();
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_gnt    = 1'b0;
      check("rst_mid_no_out", 32'(wb_if.out_valid), 32'd0);
      check("rst_mid_idle", 32'(ex_if.in_ready), 32'd1);
      check("rst_mid_no_req", 32'(bus_if.mem_req), 32'd0);
      tick();
      check("rst_mid_no_out2", 32'(wb_if.out_valid), 32'd0);

      for (int t = 0; t < 150; t++) begin
         int        kind;
         bit [31:0] ea;
         kind = $urandom_range(0, 3);
         ea   = $urandom;
         if ($urandom_range(0, 1) == 0) ea = ea - (ea % 4);
         run_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom_range(0, 7)), ea,
                 $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Memory stage between execute and writeback in the three-stage RV32I core. It accepts one instruction at a time from execute over a valid/ready handshake. Loads and stores go out on a simple request/grant/response data bus, with byte-lane alignment and load sign/zero extension. The stage then presents a registered result to writeback over valid/ready, acting as the upstream producer of writeback's valid/ready interface.

Parameters:
ADDR_W, 32, data-bus address width
XLEN, 32, datapath width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  execute result valid
in_ready  out  1  stage can accept
ex_result  in  XLEN  ALU result / effective address
store_data  in  XLEN  rs2 value for stores
funct3  in  3  RV32I load/store width code
mem_ren  in  1  instruction is a load
mem_wen  in  1  instruction is a store
rd  in  5  destination register
R_wen  in  1  register write enable
csr_wen  in  4  CSR write enables
rd_value  in  XLEN  link / CSR-read value
jump_flag  in  1  jump instruction
pc  in  XLEN  instruction pc
mem_req  out  1  bus request
mem_we  out  1  bus write
mem_addr  out  ADDR_W  word-aligned address
mem_wdata  out  XLEN  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  XLEN  read data
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
wb_MEM_Rdata  out  XLEN  extended load data
wb_Ex_result  out  XLEN  registered ex_result
wb_rd_value  out  XLEN  registered rd_value
wb_rd  out  5  registered rd
wb_R_wen  out  1  registered R_wen (forced 0 on misalign)
wb_csr_wen  out  4  registered csr_wen
wb_jump_flag  out  1  registered jump_flag
wb_mem_ren  out  1  registered mem_ren
wb_pc  out  XLEN  registered pc
wb_misalign  out  1  access was misaligned, no bus access made

Behaviour:
- Reset (reset==0 at clock edge): state IDLE. All outputs 0 except in_ready=1. Reset mid-transaction abandons it; stale mem_gnt/mem_rvalid after reset are ignored in IDLE.
- States: IDLE, REQ, RESP, OUT. in_ready=1 only in IDLE. in_valid outside IDLE is ignored.
- IDLE and in_valid: all instruction fields are latched.
  - Neither mem_ren nor mem_wen → OUT next cycle (1-cycle latency).
  - Misaligned access (half with addr[0]=1, word with addr[1:0]!=0) → OUT with wb_misalign=1 and wb_R_wen=0; no mem_req.
  - Otherwise → REQ.
  - mem_ren and mem_wen both set: treated as a load.
- REQ: mem_req=1, and mem_addr, mem_we, mem_wdata, mem_wstrb are held stable until mem_gnt.
  - On gnt, a store → OUT.
  - On gnt, a load → RESP, or directly to OUT if mem_rvalid is in the same cycle (data captured).
- RESP: wait for mem_rvalid, capture the extended data, → OUT. No timeout.
- OUT: out_valid=1 with all wb_* held stable until out_ready; on out_ready → IDLE. New instruction acceptance starts the following cycle (no bypass).
- Address: mem_addr = {ex_result[ADDR_W-1:2],2'b00}; off = ex_result[1:0].
- Stores:
  - SB: wstrb=4'b0001<<off, wdata=byte replicated x4.
  - SH: wstrb=4'b0011<<off, wdata=half replicated x2.
  - SW: wstrb=4'b1111, wdata=store_data.
- Loads: the lane is selected by off, then LB/LH sign-extend and LBU/LHU zero-extend. LW is passed through.
- Unused funct3 on a memory op: treated as word width.
- mem_wstrb=0 and mem_wdata=0 when mem_we=0.

Test Plan:
- ALU op: ex_result=0x1234, rd=5, R_wen=1 → out_valid one cycle after acceptance, wb_Ex_result=0x1234, wb_rd=5, mem_req never asserted.
- LB at 0x103 with mem_rdata=0x80FF_0000 returned 2 cycles after gnt → mem_addr=0x100, wb_MEM_Rdata=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x202, store_data=0xABCD_1234 → mem_wstrb=4'b1100, mem_wdata=0x1234_1234, mem_we=1; OUT follows on gnt with no rvalid wait.
- Grant stalled 3 cycles, then gnt and rvalid in the same cycle for LW, rdata=0xDEAD_BEEF → request fields stable throughout, wb_MEM_Rdata=0xDEAD_BEEF, RESP skipped.
- out_ready low 4 cycles → out_valid and wb_* stable, in_ready=0, a second in_valid is ignored; accepted only after drain.
- LW at 0x102 → no mem_req, wb_misalign=1, wb_R_wen=0. Separately, reset low in RESP then rvalid → state IDLE and no out_valid.
